// File: rtl/trading_decision_engine.sv
// trading_decision_engine
//   Evaluates qualifying Trade messages against runtime buy/sell thresholds.
//   It enforces a signed net-position limit and a post-decision cooldown, and
//   queues accepted decisions in a FIFO with a valid/ready output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_*               runtime configuration, sampled combinationally each cycle
//   msg_*, order_id,
//   price, size         one-cycle message strobe and payload from the parser
//   decision_*          FIFO head towards order entry (valid/ready)
//   position            signed net position of accepted decisions
//   drop_count          saturating count of decisions lost to a full FIFO
//   fifo_level          current FIFO occupancy
//
// Handshake: decision_valid is high whenever the FIFO holds an entry. A pop
// happens on any rising edge where decision_valid & decision_ready. While
// valid is high and ready is low, every decision_* output holds.
module trading_decision_engine #(
    parameter int          ID_W       = 64,
    parameter int          PRICE_W    = 32,
    parameter int          SIZE_W     = 32,
    parameter int          POS_W      = 40,
    parameter logic [7:0]  TRADE_TYPE = 8'h05,
    parameter int          FIFO_DEPTH = 4,
    parameter int          COOLDOWN   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_enable,
    input  logic [PRICE_W-1:0]            cfg_buy_thresh,
    input  logic [PRICE_W-1:0]            cfg_sell_thresh,
    input  logic [POS_W-2:0]              cfg_pos_limit,
    input  logic                          msg_valid,
    input  logic [7:0]                    msg_type,
    input  logic [ID_W-1:0]               order_id,
    input  logic [PRICE_W-1:0]            price,
    input  logic [SIZE_W-1:0]             size,
    output logic                          decision_valid,
    input  logic                          decision_ready,
    output logic                          decision_side,
    output logic [ID_W-1:0]               decision_order_id,
    output logic [PRICE_W-1:0]            decision_price,
    output logic [SIZE_W-1:0]             decision_size,
    output logic [POS_W-1:0]              position,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int ENT_W = 1 + ID_W + PRICE_W + SIZE_W;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
    logic [ENT_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [POS_W-1:0] position_q, position_d;
    logic [CD_W-1:0]  cooldown_q, cooldown_d;
    logic [15:0]      drop_q, drop_d;

    logic candidate, want_buy, want_sell, buy_ok, sell_ok;
    logic decide, side, pop, push, drop;
    logic [ENT_W-1:0] new_entry;

    // Limit arithmetic is one bit wider than the position so that the sum or
    // difference with a full-width size can never wrap.
    logic signed [POS_W:0] pos_ext, size_ext, lim_ext, pos_buy, pos_sell;

    always_comb begin
        pos_ext  = {position_q[POS_W-1], position_q};
        size_ext = {{(POS_W + 1 - SIZE_W){1'b0}}, size};
        lim_ext  = {2'b00, cfg_pos_limit};
        pos_buy  = pos_ext + size_ext;
        pos_sell = pos_ext - size_ext;
        buy_ok   = (pos_buy <= lim_ext);
        sell_ok  = (pos_sell >= -lim_ext);

        candidate = msg_valid && cfg_enable && (msg_type == TRADE_TYPE) &&
                    (size != '0) && (cooldown_q == '0);
        // Buy has priority when both thresholds match.
        want_buy  = (price < cfg_buy_thresh);
        want_sell = !want_buy && (price > cfg_sell_thresh);
        side      = !want_buy;
        decide    = candidate && ((want_buy && buy_ok) || (want_sell && sell_ok));

        pop  = (level_q != '0) && decision_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push = decide && ((level_q < LVL_W'(FIFO_DEPTH)) || pop);
        drop = decide && !push;

        new_entry = {side, order_id, price, size};

        position_d = position_q;
        if (push) position_d = side ? pos_sell[POS_W-1:0] : pos_buy[POS_W-1:0];

        cooldown_d = cooldown_q;
        if (push)                   cooldown_d = CD_W'(COOLDOWN);
        else if (cooldown_q != '0)  cooldown_d = cooldown_q - CD_W'(1);

        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

        level_d = level_q;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = new_entry;

        // The head register looks at the post-write memory so a push into an
        // empty FIFO appears on the outputs one edge later; when the FIFO
        // drains, the last head is held.
        head_d = (level_d != '0) ? mem_d[rd_ptr_d] : head_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            head_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            position_q <= '0;
            cooldown_q <= '0;
            drop_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            position_q <= position_d;
            cooldown_q <= cooldown_d;
            drop_q     <= drop_d;
        end
    end

    assign decision_valid = (level_q != '0);
    assign {decision_side, decision_order_id, decision_price, decision_size} = head_q;
    assign position   = position_q;
    assign drop_count = drop_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_trading_decision_engine.sv
module tb_trading_decision_engine;
    localparam int ID_W = 64, PRICE_W = 32, SIZE_W = 32, POS_W = 40, DEPTH = 4;
    localparam int ENT_W = 1 + ID_W + PRICE_W + SIZE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               cfg_enable;
    logic [PRICE_W-1:0] cfg_buy_thresh, cfg_sell_thresh;
    logic [POS_W-2:0]   cfg_pos_limit;
    logic               msg_valid, cd_msg_valid;
    logic [7:0]         msg_type;
    logic [ID_W-1:0]    order_id;
    logic [PRICE_W-1:0] price;
    logic [SIZE_W-1:0]  size;
    logic               decision_ready, cd_ready;

    logic               d_valid, d_side;
    logic [ID_W-1:0]    d_id;
    logic [PRICE_W-1:0] d_price;
    logic [SIZE_W-1:0]  d_size;
    logic [POS_W-1:0]   position;
    logic [15:0]        drop_count;
    logic [2:0]         fifo_level;

    logic               cd_valid, cd_side;
    logic [ID_W-1:0]    cd_id;
    logic [PRICE_W-1:0] cd_price;
    logic [SIZE_W-1:0]  cd_size;
    logic [POS_W-1:0]   cd_position;
    logic [15:0]        cd_drop;
    logic [2:0]         cd_level;

    int checks = 0;
    int errors = 0;
    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] mon_exp;

    trading_decision_engine #(.FIFO_DEPTH(DEPTH), .COOLDOWN(0)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_buy_thresh(cfg_buy_thresh), .cfg_sell_thresh(cfg_sell_thresh),
        .cfg_pos_limit(cfg_pos_limit), .msg_valid(msg_valid), .msg_type(msg_type),
        .order_id(order_id), .price(price), .size(size),
        .decision_valid(d_valid), .decision_ready(decision_ready),
        .decision_side(d_side), .decision_order_id(d_id), .decision_price(d_price),
        .decision_size(d_size), .position(position), .drop_count(drop_count),
        .fifo_level(fifo_level));

    trading_decision_engine #(.FIFO_DEPTH(DEPTH), .COOLDOWN(2)) dut_cd (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_buy_thresh(cfg_buy_thresh), .cfg_sell_thresh(cfg_sell_thresh),
        .cfg_pos_limit(cfg_pos_limit), .msg_valid(cd_msg_valid), .msg_type(msg_type),
        .order_id(order_id), .price(price), .size(size),
        .decision_valid(cd_valid), .decision_ready(cd_ready),
        .decision_side(cd_side), .decision_order_id(cd_id), .decision_price(cd_price),
        .decision_size(cd_size), .position(cd_position), .drop_count(cd_drop),
        .fifo_level(cd_level));

    // Scoreboard: every handshake on the main instance pops one expected entry.
    always @(negedge clk) begin
        if (!rst && d_valid && decision_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got id=%0d, none expected", d_id);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({d_side, d_id, d_price, d_size} !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_entry got side=%0b id=%0d price=%0d size=%0d exp side=%0b id=%0d price=%0d size=%0d",
                             d_side, d_id, d_price, d_size, mon_exp[ENT_W-1],
                             mon_exp[ENT_W-2 -: ID_W], mon_exp[PRICE_W+SIZE_W-1 -: PRICE_W],
                             mon_exp[SIZE_W-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic expect_push(input logic s, input logic [ID_W-1:0] id,
                               input logic [PRICE_W-1:0] p, input logic [SIZE_W-1:0] z);
        exp_q.push_back({s, id, p, z});
    endtask

    task automatic send(input logic to_cd, input logic [7:0] t, input logic [ID_W-1:0] id,
                        input logic [PRICE_W-1:0] p, input logic [SIZE_W-1:0] z);
        msg_valid = !to_cd; cd_msg_valid = to_cd;
        msg_type = t; order_id = id; price = p; size = z;
        @(posedge clk); #1;
        msg_valid = 1'b0; cd_msg_valid = 1'b0;
    endtask

    task automatic drain();
        decision_ready = 1'b1;
        for (int i = 0; i < 20 && fifo_level != 3'd0; i++) begin
            @(posedge clk); #1;
        end
        decision_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL drain level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", d_valid); end
        checks++; if (position !== 40'd0) begin errors++; $display("FAIL rst_pos got %0d exp 0", $signed(position)); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        checks++; if ({d_side, d_id, d_price, d_size} !== '0) begin errors++; $display("FAIL rst_data got id=%0d price=%0d", d_id, d_price); end
        rst = 1'b0;
    endtask

    task automatic test_buy();
        expect_push(1'b0, 64'd7, 32'd99999, 32'd10);
        send(1'b0, 8'h05, 64'd7, 32'd99999, 32'd10);
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL buy_valid got %0b exp 1", d_valid); end
        checks++; if (d_side !== 1'b0) begin errors++; $display("FAIL buy_side got %0b exp 0", d_side); end
        checks++; if (d_id !== 64'd7) begin errors++; $display("FAIL buy_id got %0d exp 7", d_id); end
        checks++; if (d_size !== 32'd10) begin errors++; $display("FAIL buy_size got %0d exp 10", d_size); end
        checks++; if (position !== 40'd10) begin errors++; $display("FAIL buy_pos got %0d exp 10", $signed(position)); end
        drain();
    endtask

    task automatic test_sell_and_ignore();
        expect_push(1'b1, 64'd8, 32'd200001, 32'd4);
        send(1'b0, 8'h05, 64'd8, 32'd200001, 32'd4);
        checks++; if (d_side !== 1'b1) begin errors++; $display("FAIL sell_side got %0b exp 1", d_side); end
        checks++; if (position !== 40'd6) begin errors++; $display("FAIL sell_pos got %0d exp 6", $signed(position)); end
        send(1'b0, 8'h05, 64'd9, 32'd150000, 32'd3);   // between thresholds
        send(1'b0, 8'h41, 64'd10, 32'd1, 32'd3);       // not a Trade
        cfg_enable = 1'b0;
        send(1'b0, 8'h05, 64'd11, 32'd1, 32'd3);       // engine disabled
        cfg_enable = 1'b1;
        send(1'b0, 8'h05, 64'd12, 32'd1, 32'd0);       // zero size
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL ignore_level got %0d exp 1", fifo_level); end
        checks++; if (position !== 40'd6) begin errors++; $display("FAIL ignore_pos got %0d exp 6", $signed(position)); end
        drain();
    endtask

    task automatic test_side_priority();
        cfg_buy_thresh = 32'd300000;                   // both thresholds now match
        expect_push(1'b0, 64'd13, 32'd250000, 32'd4);
        send(1'b0, 8'h05, 64'd13, 32'd250000, 32'd4);
        checks++; if (d_side !== 1'b0) begin errors++; $display("FAIL prio_side got %0b exp 0", d_side); end
        checks++; if (position !== 40'd10) begin errors++; $display("FAIL prio_pos got %0d exp 10", $signed(position)); end
        cfg_buy_thresh = 32'd100000;
        drain();
    endtask

    task automatic test_pos_limit();
        cfg_pos_limit = 39'd15;
        expect_push(1'b0, 64'd21, 32'd99999, 32'd5);
        send(1'b0, 8'h05, 64'd21, 32'd99999, 32'd5);
        checks++; if (position !== 40'd15) begin errors++; $display("FAIL lim_pos15 got %0d exp 15", $signed(position)); end
        send(1'b0, 8'h05, 64'd22, 32'd99999, 32'd1);   // 16 > 15
        send(1'b0, 8'h05, 64'd23, 32'd200001, 32'd31); // -16 < -15
        checks++; if (position !== 40'd15) begin errors++; $display("FAIL lim_block_pos got %0d exp 15", $signed(position)); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL lim_block_level got %0d exp 1", fifo_level); end
        expect_push(1'b1, 64'd24, 32'd200001, 32'd30);
        send(1'b0, 8'h05, 64'd24, 32'd200001, 32'd30); // exactly -15
        send(1'b0, 8'h05, 64'd25, 32'd200001, 32'd1);  // -16 blocked
        checks++; if (position !== -40'sd15) begin errors++; $display("FAIL lim_neg_pos got %0d exp -15", $signed(position)); end
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL lim_neg_level got %0d exp 2", fifo_level); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL lim_drop got %0d exp 0", drop_count); end
        drain();
        cfg_pos_limit = 39'd1000;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH) expect_push(1'b0, 64'(100 + i), 32'(50000 + i), 32'd1);
            send(1'b0, 8'h05, 64'(100 + i), 32'(50000 + i), 32'd1);
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d exp 4", fifo_level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL bp_drop got %0d exp 2", drop_count); end
        checks++; if (position !== -40'sd11) begin errors++; $display("FAIL bp_pos got %0d exp -11", $signed(position)); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (d_valid !== 1'b1 || d_id !== 64'd100 || d_price !== 32'd50000 || d_size !== 32'd1) begin
            errors++; $display("FAIL bp_stable got valid=%0b id=%0d price=%0d exp 1/100/50000", d_valid, d_id, d_price);
        end
        drain();
    endtask

    task automatic test_full_with_pop();
        for (int i = 0; i < DEPTH; i++) begin
            expect_push(1'b0, 64'(200 + i), 32'd60000, 32'd1);
            send(1'b0, 8'h05, 64'(200 + i), 32'd60000, 32'd1);
        end
        decision_ready = 1'b1;
        expect_push(1'b0, 64'd204, 32'd60000, 32'd1);
        send(1'b0, 8'h05, 64'd204, 32'd60000, 32'd1);
        decision_ready = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_level got %0d exp 4", fifo_level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL fp_drop got %0d exp 2", drop_count); end
        checks++; if (position !== -40'sd6) begin errors++; $display("FAIL fp_pos got %0d exp -6", $signed(position)); end
        checks++; if (d_id !== 64'd201) begin errors++; $display("FAIL fp_head got %0d exp 201", d_id); end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            expect_push(1'b0, 64'(300 + i), 32'd70000, 32'd1);
            send(1'b0, 8'h05, 64'(300 + i), 32'd70000, 32'd1);
        end
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL rm_level_pre got %0d exp 3", fifo_level); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %0b exp 0", d_valid); end
        checks++; if (position !== 40'd0) begin errors++; $display("FAIL rm_pos got %0d exp 0", $signed(position)); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rm_drop got %0d exp 0", drop_count); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rm_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_cooldown();
        for (int i = 1; i <= 4; i++) send(1'b1, 8'h05, 64'(i), 32'd99999, 32'd1);
        checks++; if (cd_level !== 3'd2) begin errors++; $display("FAIL cd_level got %0d exp 2", cd_level); end
        checks++; if (cd_position !== 40'd2) begin errors++; $display("FAIL cd_pos got %0d exp 2", $signed(cd_position)); end
        checks++; if (cd_id !== 64'd1) begin errors++; $display("FAIL cd_head1 got %0d exp 1", cd_id); end
        cd_ready = 1'b1;
        @(posedge clk); #1;
        cd_ready = 1'b0;
        checks++; if (cd_id !== 64'd4) begin errors++; $display("FAIL cd_head2 got %0d exp 4", cd_id); end
        checks++; if (cd_drop !== 16'd0) begin errors++; $display("FAIL cd_drop got %0d exp 0", cd_drop); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL cd_main_level got %0d exp 0", fifo_level); end
    endtask

    initial begin
        cfg_enable = 1'b1; cfg_buy_thresh = 32'd100000; cfg_sell_thresh = 32'd200000;
        cfg_pos_limit = 39'd1000; msg_valid = 1'b0; cd_msg_valid = 1'b0;
        msg_type = 8'h00; order_id = '0; price = '0; size = '0;
        decision_ready = 1'b0; cd_ready = 1'b0;
        test_reset();
        test_buy();
        test_sell_and_ignore();
        test_side_priority();
        test_pos_limit();
        test_backpressure();
        test_full_with_pop();
        test_reset_mid();
        test_cooldown();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trading_decision_engine.md
Name: trading_decision_engine

Overview:
Parametrised successor to the single-threshold buy filter. It evaluates Trade messages against runtime-configurable buy and sell thresholds. It enforces a signed net-position limit and a post-decision cooldown. Accepted decisions queue in a FIFO with a valid/ready output, so a stalled order-entry stage never loses state silently. It sits between the message parser and order-entry logic.

Parameters:
ID_W, 64, order_id width
PRICE_W, 32, price and threshold width (unsigned)
SIZE_W, 32, size width (unsigned)
POS_W, 40, signed position width; must be > SIZE_W
TRADE_TYPE, 8'h05, msg_type value that qualifies for evaluation
FIFO_DEPTH, 4, decision FIFO entries; power of 2, >= 2
COOLDOWN, 0, cycles of suppression after each accepted decision; 0 disables

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_enable  in  1  1 = evaluate messages; 0 = ignore all messages
cfg_buy_thresh  in  PRICE_W  buy when price < this
cfg_sell_thresh  in  PRICE_W  sell when price > this
cfg_pos_limit  in  POS_W-1  absolute net-position limit (unsigned)
msg_valid  in  1  message strobe, one cycle per message
msg_type  in  8  message type
order_id  in  ID_W  message order id
price  in  PRICE_W  message price
size  in  SIZE_W  message size
decision_valid  out  1  FIFO head valid
decision_ready  in  1  consumer accepts head
decision_side  out  1  0 = buy, 1 = sell
decision_order_id  out  ID_W  head order id
decision_price  out  PRICE_W  head price
decision_size  out  SIZE_W  head size
position  out  POS_W  signed net position of accepted decisions
drop_count  out  16  saturating count of decisions lost to a full FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state updates on the rising edge of clk.
- Reset: FIFO empty, decision_valid=0, all decision_* data 0, position=0, drop_count=0, cooldown=0, fifo_level=0.
- Reset mid-operation discards queued decisions. Config inputs are sampled combinationally every cycle.
- Candidate: msg_valid & cfg_enable & msg_type==TRADE_TYPE & size!=0 & cooldown==0.
- Side selection: buy if price < cfg_buy_thresh; otherwise sell if price > cfg_sell_thresh; otherwise no decision. Buy wins if both thresholds match.
- Limit check uses POS_W+1-bit signed arithmetic with size zero-extended:
  - buy allowed iff position + size <= +cfg_pos_limit;
  - sell allowed iff position - size >= -cfg_pos_limit.
  - A limit-blocked candidate produces no decision and no count.
- Push/pop rules:
  - pop = decision_valid & decision_ready.
  - push allowed iff fifo_level < FIFO_DEPTH, or pop occurs in the same cycle (full with simultaneous pop is accepted).
- Accepted decision at edge N: written to FIFO, position += size (buy) or -= size (sell), cooldown loaded with COOLDOWN.
- Latency: if the FIFO was empty, decision_valid=1 with this entry after edge N (1 cycle, same as the predecessor).
- Dropped decision (FIFO full, no pop): no FIFO write, no position change, cooldown not loaded. drop_count += 1, saturating at 16'hFFFF.
- Cooldown: decrements by 1 each cycle while nonzero. Candidates seen while cooldown != 0 are silently ignored and not counted.
- Output stability: while decision_valid & !decision_ready, all decision_* outputs hold. Heads are presented in FIFO order.
- decision_valid = (fifo_level != 0). decision_* are undriven-safe: they show the head entry and hold the last value when empty.
- fifo_level updates as +1 on push only, -1 on pop only, unchanged on push+pop.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset then buy: buy=100000, sell=200000, limit=1000; Trade (05) at price 99999, size 10, id 7 -> after 1 cycle decision_valid=1, side=0, id=7, size=10; position=10.
- Sell and no-decision: Trade at price 200001, size 4 -> side=1, position -4. Trade at price 150000 -> no decision. Non-Trade type 0x41 at price 1 -> ignored.
- Position limit: limit=15, position=10; buy size 5 -> accepted, position=15. Buy size 1 -> blocked. Sell size 30 -> blocked (15-30 = -15 is allowed, so use size 31) -> no decision, position stays 15.
- Backpressure/full: FIFO_DEPTH=4, decision_ready=0, 6 qualifying buys on consecutive cycles -> fifo_level=4, drop_count=2, position counts only 4. Raise ready -> the 4 entries drain in order, outputs stable while stalled.
- Full with simultaneous pop: FIFO full, ready=1 and qualifying message in the same cycle -> accepted, fifo_level stays 4, drop_count unchanged.
- Cooldown/reset: COOLDOWN=2, qualifying messages on cycles N, N+1, N+2, N+3 -> decisions only from N and N+3. Assert rst with 3 queued -> decision_valid=0, position=0, drop_count=0 next cycle.
